// File: rtl/divider_ctrl_pkg.sv
// Shared types and constants for the divider sequencing controller.
// State encoding, zero-divisor quotient pattern and iteration counter width.
package divider_ctrl_pkg;

    localparam int DIV_WIDTH = 8;
    localparam int ITER_W    = $clog2(DIV_WIDTH);

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_ADDSUB  = 3'd4,
        ST_CORRECT = 3'd5,
        ST_FINISH  = 3'd6
    } state_t;

endpackage

// File: rtl/divider_ctrl.sv
// Sequencer for the non-restoring divider datapath: 21 cycles accept-to-out_valid, 1 cycle for a zero divisor.
// Backpressure: ready only in IDLE; start is ignored while busy, operands are held for the whole operation.
module divider_ctrl
    import divider_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             ready,
    output logic             busy,
    input  logic             dp_sign,
    output logic             dp_reset,
    output logic             dp_load,
    output logic             dp_shift_en,
    output logic             dp_add_en,
    output logic             dp_sub_en,
    output logic             dp_final_add,
    output logic             dp_count_en,
    output logic [WIDTH-1:0] dp_dividend,
    output logic [WIDTH-1:0] dp_divisor,
    input  logic [WIDTH-1:0] dp_quotient,
    input  logic [WIDTH-1:0] dp_remainder,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out,
    output logic             div_zero,
    output logic             out_valid
);

    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(WIDTH - 1);

    state_t            state_q;
    logic [ITER_W-1:0] iter_q;
    logic [WIDTH-1:0]  dividend_q;
    logic [WIDTH-1:0]  divisor_q;
    logic [WIDTH-1:0]  quotient_q;
    logic [WIDTH-1:0]  remainder_q;
    logic              div_zero_q;
    logic              out_valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            iter_q      <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (divisor_in != '0) begin
                            dividend_q <= dividend_in;
                            divisor_q  <= divisor_in;
                            iter_q     <= '0;
                            state_q    <= ST_CLEAR;
                        end else begin
                            // Zero divisor never touches the datapath; answer straight from IDLE.
                            quotient_q  <= WIDTH'(DIV_ZERO_QUOTIENT);
                            remainder_q <= dividend_in;
                            div_zero_q  <= 1'b1;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_CLEAR:   state_q <= ST_LOAD;
                ST_LOAD:    state_q <= ST_SHIFT;
                ST_SHIFT:   state_q <= ST_ADDSUB;
                ST_ADDSUB: begin
                    iter_q  <= iter_q + 1'b1;
                    state_q <= (iter_q == ITER_LAST) ? ST_CORRECT : ST_SHIFT;
                end
                ST_CORRECT: state_q <= ST_FINISH;
                ST_FINISH: begin
                    quotient_q  <= dp_quotient;
                    remainder_q <= dp_remainder;
                    div_zero_q  <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready = (state_q == ST_IDLE);
    assign busy  = (state_q != ST_IDLE);

    // dp_reset also follows the controller reset so the datapath clears with it.
    assign dp_reset     = !reset_n || (state_q == ST_CLEAR);
    assign dp_load      = (state_q == ST_LOAD);
    assign dp_shift_en  = (state_q == ST_SHIFT);
    assign dp_count_en  = (state_q == ST_SHIFT);
    assign dp_add_en    = (state_q == ST_ADDSUB) &&  dp_sign;
    assign dp_sub_en    = (state_q == ST_ADDSUB) && !dp_sign;
    assign dp_final_add = (state_q == ST_CORRECT);

    assign dp_dividend   = dividend_q;
    assign dp_divisor    = divisor_q;
    assign quotient_out  = quotient_q;
    assign remainder_out = remainder_q;
    assign div_zero      = div_zero_q;
    assign out_valid     = out_valid_q;

endmodule
